// File: rtl/datapath_controller_pkg.sv
// Shared encodings for the 16-bit datapath and its sequencing controller.
// The ALU select/op values must stay in step with the datapath muxes.
package datapath_defines;

  localparam logic [3:0] OPC_REG   = 4'b0000;
  localparam logic [3:0] OPC_ADDI  = 4'b0101;
  localparam logic [3:0] OPC_SUBI  = 4'b1001;
  localparam logic [3:0] OPC_ADDUI = 4'b0110;

  localparam logic [3:0] EXT_NOP = 4'b0000;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;

  localparam logic [1:0] ALU_A_PC       = 2'b00;
  localparam logic [1:0] ALU_A_SRC      = 2'b01;
  localparam logic [1:0] ALU_A_IMM_SEXT = 2'b10;
  localparam logic [1:0] ALU_A_IMM_ZEXT = 2'b11;

  localparam logic ALU_B_DEST = 1'b0;
  localparam logic ALU_B_ONE  = 1'b1;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_LOAD      = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Controller <-> datapath control bundle: instruction/handshake in, mux selects and write enables out.
interface datapath_controller_if;
  logic [15:0] instruction;
  logic        memory_ready;
  logic [1:0]  alu_a_select;
  logic        alu_b_select;
  logic [1:0]  alu_operation;
  logic        program_counter_write_enable;
  logic        instruction_write_enable;
  logic        register_write_enable;

  modport master (
    input  instruction, memory_ready,
    output alu_a_select, alu_b_select, alu_operation,
           program_counter_write_enable, instruction_write_enable, register_write_enable
  );

  modport slave (
    output instruction, memory_ready,
    input  alu_a_select, alu_b_select, alu_operation,
           program_counter_write_enable, instruction_write_enable, register_write_enable
  );
endinterface

// File: rtl/datapath_controller_decoder.sv
// Combinational instruction classifier: legality, NOP detection and ALU selects/operation.
module instruction_decoder
  import datapath_defines::*;
(
  input  logic [15:0] instruction,
  output logic        legal,
  output logic        nop,
  output logic [1:0]  a_select,
  output logic        b_select,
  output logic [1:0]  operation
);

  logic [3:0] opcode;
  logic [3:0] ext;
  logic       unused_fields;

  assign opcode        = instruction[15:12];
  assign ext           = instruction[7:4];
  assign unused_fields = ^{instruction[11:8], instruction[3:0]};

  always_comb begin
    legal     = 1'b0;
    nop       = 1'b0;
    a_select  = ALU_A_PC;
    b_select  = ALU_B_DEST;
    operation = ALU_OP_ADD;
    case (opcode)
      OPC_REG: begin
        case (ext)
          EXT_NOP: begin legal = 1'b1; nop = 1'b1; end
          EXT_ADD: begin legal = 1'b1; a_select = ALU_A_SRC; end
          EXT_SUB: begin legal = 1'b1; a_select = ALU_A_SRC; operation = ALU_OP_SUB; end
          default: legal = 1'b0;
        endcase
      end
      OPC_ADDI:  begin legal = 1'b1; a_select = ALU_A_IMM_SEXT; end
      OPC_SUBI:  begin legal = 1'b1; a_select = ALU_A_IMM_SEXT; operation = ALU_OP_SUB; end
      OPC_ADDUI: begin legal = 1'b1; a_select = ALU_A_IMM_ZEXT; end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Moore sequencer for the 16-bit datapath: fetch, PC increment, decode, execute, writeback.
// state     | meaning
// FETCH     | PC on memory bus, wait for memory_ready
// LOAD      | capture instruction and PC <- PC+1 on the same edge
// DECODE    | classify instruction, latch selects/op
// EXECUTE   | drive latched selects, datapath captures ALU result
// WRITEBACK | same selects, write result into rdest
// HALT      | illegal instruction seen, idle until reset
module datapath_controller
  import datapath_defines::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  datapath_controller_if.master  dp,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instructions_retired
);

  state_t     state, state_nx;
  logic       dec_legal, dec_nop, dec_b;
  logic [1:0] dec_a, dec_op;
  logic [1:0] lat_a, lat_op;
  logic       lat_b;
  logic [1:0] a_sel, op_sel;
  logic       b_sel, pc_we, ir_we, rf_we;
  logic       retire;

  instruction_decoder u_decoder (
    .instruction (dp.instruction),
    .legal       (dec_legal),
    .nop         (dec_nop),
    .a_select    (dec_a),
    .b_select    (dec_b),
    .operation   (dec_op)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_a  <= ALU_A_PC;
      lat_b  <= ALU_B_DEST;
      lat_op <= ALU_OP_ADD;
    end else if (state == S_DECODE) begin
      lat_a  <= dec_a;
      lat_b  <= dec_b;
      lat_op <= dec_op;
    end
  end

  assign retire = ((state == S_DECODE) && dec_legal && dec_nop) || (state == S_WRITEBACK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted               <= 1'b0;
      instructions_retired <= '0;
    end else begin
      if ((state == S_DECODE) && !dec_legal) halted <= 1'b1;
      if (retire) instructions_retired <= instructions_retired + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nx = state;
    a_sel    = ALU_A_PC;
    b_sel    = ALU_B_DEST;
    op_sel   = ALU_OP_ADD;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    case (state)
      S_FETCH: if (dp.memory_ready) state_nx = S_LOAD;
      S_LOAD: begin
        ir_we    = 1'b1;
        pc_we    = 1'b1;
        b_sel    = ALU_B_ONE;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (!dec_legal)  state_nx = S_HALT;
        else if (dec_nop) state_nx = S_FETCH;
        else              state_nx = S_EXECUTE;
      end
      S_EXECUTE: begin
        a_sel    = lat_a;
        b_sel    = lat_b;
        op_sel   = lat_op;
        state_nx = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        a_sel    = lat_a;
        b_sel    = lat_b;
        op_sel   = lat_op;
        rf_we    = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  assign dp.alu_a_select                 = a_sel;
  assign dp.alu_b_select                 = b_sel;
  assign dp.alu_operation                = op_sel;
  assign dp.program_counter_write_enable = pc_we;
  assign dp.instruction_write_enable     = ir_we;
  assign dp.register_write_enable        = rf_we;

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench: per-cycle expected control vectors derived from instruction semantics.
module tb_datapath_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tb_instr = 16'h0000;
  logic        tb_ready = 1'b0;

  logic        halted, halted_s;
  logic [15:0] retired;
  logic [2:0]  retired_s;

  int total = 0;
  int bad   = 0;
  int ret_m = 0;
  logic halted_m = 1'b0;

  datapath_controller_if dp_if();
  datapath_controller_if dp_if_s();

  assign dp_if.instruction    = tb_instr;
  assign dp_if.memory_ready   = tb_ready;
  assign dp_if_s.instruction  = tb_instr;
  assign dp_if_s.memory_ready = tb_ready;

  datapath_controller #(.COUNT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset), .dp(dp_if),
    .halted(halted), .instructions_retired(retired)
  );

  datapath_controller #(.COUNT_WIDTH(3)) u_small (
    .clock(clock), .reset(reset), .dp(dp_if_s),
    .halted(halted_s), .instructions_retired(retired_s)
  );

  always #5 clock = ~clock;

  // control vector: {a[1:0], b, op[1:0], pcwe, iwe, rwe}
  logic [7:0] ctl_act, ctl_act_s;
  assign ctl_act = {dp_if.alu_a_select, dp_if.alu_b_select, dp_if.alu_operation,
                    dp_if.program_counter_write_enable, dp_if.instruction_write_enable,
                    dp_if.register_write_enable};
  assign ctl_act_s = {dp_if_s.alu_a_select, dp_if_s.alu_b_select, dp_if_s.alu_operation,
                      dp_if_s.program_counter_write_enable, dp_if_s.instruction_write_enable,
                      dp_if_s.register_write_enable};

  localparam logic [7:0] IDLE = 8'h00;
  localparam logic [7:0] LOADV = 8'b00_1_00_110;

  typedef enum int {K_ALU, K_NOP, K_ILL} kind_t;
  typedef struct {
    logic [15:0] ins;
    int          wait_cycles;
    kind_t       kind;
    logic [1:0]  a;
    logic        b;
    logic [1:0]  op;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic [7:0] exp);
    int rm;
    rm = ret_m;
    tb_ready = rdy;
    @(negedge clock);
    check("ctl", {24'd0, ctl_act}, {24'd0, exp});
    check("ctl_small", {24'd0, ctl_act_s}, {24'd0, exp});
    check("halted", {31'd0, halted}, {31'd0, halted_m});
    check("retired", {16'd0, retired}, {16'd0, rm[15:0]});
    check("retired_small", {29'd0, retired_s}, {29'd0, rm[2:0]});
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tb_ready = 1'b0;
    ret_m = 0;
    halted_m = 1'b0;
    @(negedge clock);
    check("rst_ctl", {24'd0, ctl_act}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Reference classification straight from the instruction set table.
  function automatic vec_t model_decode(input logic [15:0] ins);
    vec_t v;
    logic [3:0] opc, ext;
    opc = ins[15:12];
    ext = ins[7:4];
    v.ins = ins; v.wait_cycles = 0; v.kind = K_ILL; v.a = 2'b00; v.b = 1'b0; v.op = 2'b00;
    if (opc == 4'h0 && ext == 4'h0)      v.kind = K_NOP;
    else if (opc == 4'h0 && ext == 4'h5) begin v.kind = K_ALU; v.a = 2'b01; end
    else if (opc == 4'h0 && ext == 4'h9) begin v.kind = K_ALU; v.a = 2'b01; v.op = 2'b01; end
    else if (opc == 4'h5)                begin v.kind = K_ALU; v.a = 2'b10; end
    else if (opc == 4'h9)                begin v.kind = K_ALU; v.a = 2'b10; v.op = 2'b01; end
    else if (opc == 4'h6)                begin v.kind = K_ALU; v.a = 2'b11; end
    return v;
  endfunction

  task automatic run_instr(input vec_t v);
    logic [7:0] sel;
    tb_instr = v.ins;
    sel = {v.a, v.b, v.op, 3'b000};
    for (int i = 0; i < v.wait_cycles; i++) step(1'b0, IDLE);
    step(1'b1, IDLE);
    step(1'($urandom_range(0, 1)), LOADV);
    step(1'($urandom_range(0, 1)), IDLE);
    case (v.kind)
      K_ALU: begin
        step(1'($urandom_range(0, 1)), sel);
        step(1'($urandom_range(0, 1)), sel | 8'h01);
        ret_m++;
      end
      K_NOP: ret_m++;
      default: begin
        halted_m = 1'b1;
        for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), IDLE);
        do_reset();
      end
    endcase
  endtask

  vec_t table_v[$];

  initial begin
    vec_t v;
    int   sel;
    table_v.push_back('{16'h0153, 0, K_ALU, 2'b01, 1'b0, 2'b00});
    table_v.push_back('{16'h92FF, 0, K_ALU, 2'b10, 1'b0, 2'b01});
    table_v.push_back('{16'h6280, 0, K_ALU, 2'b11, 1'b0, 2'b00});
    table_v.push_back('{16'h0000, 0, K_NOP, 2'b00, 1'b0, 2'b00});
    table_v.push_back('{16'h0153, 4, K_ALU, 2'b01, 1'b0, 2'b00});
    table_v.push_back('{16'h0193, 1, K_ALU, 2'b01, 1'b0, 2'b01});
    table_v.push_back('{16'h5A7C, 2, K_ALU, 2'b10, 1'b0, 2'b00});
    table_v.push_back('{16'h0F0F, 0, K_NOP, 2'b00, 1'b0, 2'b00});
    table_v.push_back('{16'hF000, 0, K_ILL, 2'b00, 1'b0, 2'b00});
    table_v.push_back('{16'h0010, 1, K_ILL, 2'b00, 1'b0, 2'b00});
    table_v.push_back('{16'h6FFF, 0, K_ALU, 2'b11, 1'b0, 2'b00});

    @(posedge clock);
    do_reset();

    foreach (table_v[i]) run_instr(table_v[i]);

    // Reset asserted during EXECUTE: outputs drop at once, no writeback.
    tb_instr = 16'h0153;
    step(1'b1, IDLE);
    step(1'b0, LOADV);
    step(1'b0, IDLE);
    @(negedge clock);
    check("exec_before_rst", {24'd0, ctl_act}, {24'd0, 8'b01_0_00_000});
    #2 reset = 1'b0;
    #1;
    check("exec_async_rst", {24'd0, ctl_act}, 32'd0);
    check("exec_async_rst_cnt", {16'd0, retired}, 32'd0);
    @(negedge clock);
    check("exec_rst_no_rwe", {31'd0, dp_if.register_write_enable}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    ret_m = 0;
    halted_m = 1'b0;

    // Ten NOPs: the 3-bit counter instance wraps from 7 to 0.
    for (int i = 0; i < 10; i++) run_instr(model_decode(16'h0000));
    check("wrap_small", {29'd0, retired_s}, 32'd2);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: v = model_decode({4'h0, 4'($urandom), 4'h5, 4'($urandom)});
        1: v = model_decode({4'h0, 4'($urandom), 4'h9, 4'($urandom)});
        2: v = model_decode({4'h0, 4'($urandom), 4'h0, 4'($urandom)});
        3: v = model_decode({4'h5, 12'($urandom)});
        4: v = model_decode({4'h9, 12'($urandom)});
        5: v = model_decode({4'h6, 12'($urandom)});
        default: v = model_decode(16'($urandom));
      endcase
      v.wait_cycles = $urandom_range(0, 3);
      run_instr(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
